ucode_loader: RTL and testbench
===============================

# ucode_loader

Serial program loader sitting directly upstream of the uCode CPU. Accepts a byte stream over a valid/ready handshake, parses framed load records, and writes 16-bit words into the CPU's uCode program memory through its write port (write enable, address, data). After a well-formed frame completes, it drives the CPU's run input. A new frame stops the CPU and reloads it.

## Interface
- `ADDR_SZ`, 8: uCode address width (≤ 8); low `ADDR_SZ` bits of the address byte are used.
- `DATA_SZ`, 16: uCode word width; fixed at 16 (two bytes per word).
- `SYNC`, 8'h55: frame header byte.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  incoming byte.
- `i_rx_valid`  in  1  `i_rx_data` valid.
- `o_rx_ready`  out  1  loader accepts a byte this cycle.
- `o_wr`  out  1  one-cycle uCode write strobe.
- `o_waddr`  out  ADDR_SZ  uCode write address.
- `o_wdata`  out  16  uCode write data.
- `o_run`  out  1  run request to the CPU.
- `o_error`  out  1  last frame failed; sticky until reset or next header.

## Operation
- Byte accepted on a rising edge where `i_rx_valid && o_rx_ready`.
- Frame format: `SYNC`, ADDR, COUNT, then COUNT words sent as hi byte then lo byte, then CSUM (only when checksum is enabled). COUNT = 0 means 256 words.
- States:
  - IDLE: bytes other than `SYNC` are discarded.
  - `SYNC` → HDR_A, which clears `o_run` and `o_error`.
  - HDR_A → HDR_C.
  - HDR_C → DHI.
  - DHI → DLO.
  - DLO → WR.
  - WR: emits the write for one cycle, then goes to DHI if words remain, else to CSUM or DONE.
  - CSUM: on match goes to DONE, else to ERR.
  - DONE: `o_run`=1.
  - ERR: `o_error`=1, `o_run`=0.
- In DONE and ERR, an accepted `SYNC` restarts at HDR_A. All other bytes are discarded.
- Write address starts at ADDR and increments by 1 modulo 2^ADDR_SZ after each write; 8'hFF wraps to 8'h00.
- Word counter is 9 bits, loaded with COUNT (or 256 if COUNT = 0), and decremented per write.
- Data bytes are consumed literally; a `SYNC` value inside ADDR, COUNT, data or CSUM is data, not a header.
- Running checksum is the 8-bit XOR of ADDR, COUNT and all data bytes.
- Words already written before a checksum failure remain in memory. `o_run` is not asserted.
- Reset mid-frame: the frame is abandoned and the state returns to IDLE. No write is issued after reset.

## Timing
- Reset values:
  - `o_rx_ready`=1 (first rising edge with reset deasserted can accept)
  - `o_wr`=0
  - `o_waddr`=0
  - `o_wdata`=0
  - `o_run`=0
  - `o_error`=0
  - state IDLE
- `o_rx_ready`=0 only in state WR, i.e. exactly one cycle after each DLO byte is accepted. It is 1 in all other states.
- `o_wr` is high for exactly the WR cycle. `o_waddr` and `o_wdata` are valid in that cycle and hold their values afterwards.
- `o_wdata` = {hi byte, lo byte}.
- `o_run` rises on the cycle after the final acceptance: the CSUM byte if checksum is enabled, otherwise the cycle after the last WR.
- `o_run` falls on the cycle after a `SYNC` is accepted in DONE.
- `o_error` rises on the cycle after a mismatching CSUM is accepted.
- Back-to-back bytes: sustained rate is one byte per cycle, except one stall cycle per word.
- `i_rx_data` is ignored while `i_rx_valid`=0. The upstream source must hold data while ready=0.

## Configuration
- `UCODE_LOADER_CSUM_EN` defined:
  - The CSUM byte is expected after the last data byte.
  - A mismatch enters ERR.
- `UCODE_LOADER_CSUM_EN` undefined:
  - No CSUM byte; WR goes straight to DONE after the last word.
  - ERR is unreachable and `o_error` is tied to 0.
  - The XOR logic is removed.

## Test plan
- Reset, then send 55 80 01 12 34 (+ CSUM 8'hA7 when enabled) → single `o_wr` with addr 8'h80, data 16'h1234. `o_run` rises the cycle after the last byte.
- Send 55 FF 02 AA BB CC DD (+ CSUM) → writes FF:AABB and 00:CCDD (address wraps). `o_rx_ready` is low for exactly one cycle after BB and after DD.
- Junk 00 13 then 55 00 00 followed by 512 data bytes → junk is ignored and exactly 256 writes cover 00..FF. Also: a data byte 8'h55 is written as data.
- `UCODE_LOADER_CSUM_EN` on: 55 10 01 00 01 with bad CSUM 8'h00 → write 10:0001 occurs, `o_error`=1, `o_run`=0. A following 55 clears `o_error`.
- While DONE with `o_run`=1, send 55 → `o_run` drops the next cycle. Assert `i_rst` mid-data → no further `o_wr`, and all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - framed byte-stream loader that fills uCode program memory and starts the CPU
// Define UCODE_LOADER_CSUM_EN to require a trailing XOR checksum byte per frame.
module ucode_loader #(
   parameter int          ADDR_SZ = 8,
   parameter int          DATA_SZ = 16,
   parameter logic [7:0]  SYNC    = 8'h55
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic               o_wr,
   output logic [ADDR_SZ-1:0] o_waddr,
   output logic [DATA_SZ-1:0] o_wdata,
   output logic               o_run,
   output logic               o_error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_A,
      S_HDR_C,
      S_DHI,
      S_DLO,
      S_WR,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_SZ-1:0]   addr_q, addr_d;
   logic [8:0]           cnt_q, cnt_d;
   logic [7:0]           hi_q, hi_d;
   logic [ADDR_SZ-1:0]   waddr_q, waddr_d;
   logic [DATA_SZ-1:0]   wdata_q, wdata_d;
`ifdef UCODE_LOADER_CSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif
   logic                 accept;

   // The only stall is the write cycle, so ready is a pure state decode.
   assign o_rx_ready = (state_q != S_WR);
   assign accept     = i_rx_valid && o_rx_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
`ifdef UCODE_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept && i_rx_data == SYNC) begin
               state_d = S_HDR_A;
            end
         end
         S_HDR_A: begin
            if (accept) begin
               addr_d  = i_rx_data[ADDR_SZ-1:0];
`ifdef UCODE_LOADER_CSUM_EN
               csum_d  = i_rx_data;
`endif
               state_d = S_HDR_C;
            end
         end
         S_HDR_C: begin
            if (accept) begin
               cnt_d   = (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
`ifdef UCODE_LOADER_CSUM_EN
               csum_d  = csum_q ^ i_rx_data;
`endif
               state_d = S_DHI;
            end
         end
         S_DHI: begin
            if (accept) begin
               hi_d    = i_rx_data;
`ifdef UCODE_LOADER_CSUM_EN
               csum_d  = csum_q ^ i_rx_data;
`endif
               state_d = S_DLO;
            end
         end
         S_DLO: begin
            // Output address/data are latched here so they hold after the write.
            if (accept) begin
               waddr_d = addr_q;
               wdata_d = {hi_q, i_rx_data};
               addr_d  = addr_q + ADDR_SZ'(1);
               cnt_d   = cnt_q - 9'd1;
`ifdef UCODE_LOADER_CSUM_EN
               csum_d  = csum_q ^ i_rx_data;
`endif
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (cnt_q != 9'd0) begin
               state_d = S_DHI;
            end else begin
`ifdef UCODE_LOADER_CSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef UCODE_LOADER_CSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (i_rx_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         S_ERR: begin
            if (accept && i_rx_data == SYNC) begin
               state_d = S_HDR_A;
            end
         end
`endif
         S_DONE: begin
            if (accept && i_rx_data == SYNC) begin
               state_d = S_HDR_A;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
`ifdef UCODE_LOADER_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
`ifdef UCODE_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign o_wr    = (state_q == S_WR);
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;
   assign o_run   = (state_q == S_DONE);
`ifdef UCODE_LOADER_CSUM_EN
   assign o_error = (state_q == S_ERR);
`else
   assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_loader.sv
// tb/tb_ucode_loader.sv - directed vector bench for ucode_loader
// Honours UCODE_LOADER_CSUM_EN by inserting checksum bytes and the error-frame sequence.
module tb_ucode_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr;
   logic [7:0]  waddr;
   logic [15:0] wdata;
   logic        run;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;
   int wr_count = 0;

   ucode_loader dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_rx_ready (rx_ready),
      .o_wr       (wr),
      .o_waddr    (waddr),
      .o_wdata    (wdata),
      .o_run      (run),
      .o_error    (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr) wr_count = wr_count + 1;
   end

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        wr;
      logic [7:0]  a;
      logic [15:0] wd;
      logic        run;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [7:0] d, input logic rdy,
                               input logic w, input logic [7:0] a, input logic [15:0] wd,
                               input logic r, input logic e);
      vec_t x;
      x.v = v; x.d = d; x.rdy = rdy; x.wr = w; x.a = a; x.wd = wd; x.run = r; x.err = e;
      vecs.push_back(x);
   endfunction

   function automatic logic [27:0] outs();
      return {rx_ready, wr, waddr, wdata, run, err};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int snap;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;

      // frame 1: single word at 0x80
      add(1, 8'h55, 1, 0, 8'h00, 16'h0000, 0, 0);
      add(1, 8'h80, 1, 0, 8'h00, 16'h0000, 0, 0);
      add(1, 8'h01, 1, 0, 8'h00, 16'h0000, 0, 0);
      add(1, 8'h12, 1, 0, 8'h00, 16'h0000, 0, 0);
      add(1, 8'h34, 1, 0, 8'h00, 16'h0000, 0, 0);
      add(0, 8'h00, 0, 1, 8'h80, 16'h1234, 0, 0);
`ifdef UCODE_LOADER_CSUM_EN
      add(1, 8'hA7, 1, 0, 8'h80, 16'h1234, 0, 0);
`endif
      add(1, 8'h00, 1, 0, 8'h80, 16'h1234, 1, 0);
      add(0, 8'h00, 1, 0, 8'h80, 16'h1234, 1, 0);
      // frame 2: two words wrapping FF -> 00, CC held across the stall
      add(1, 8'h55, 1, 0, 8'h80, 16'h1234, 1, 0);
      add(1, 8'hFF, 1, 0, 8'h80, 16'h1234, 0, 0);
      add(1, 8'h02, 1, 0, 8'h80, 16'h1234, 0, 0);
      add(1, 8'hAA, 1, 0, 8'h80, 16'h1234, 0, 0);
      add(1, 8'hBB, 1, 0, 8'h80, 16'h1234, 0, 0);
      add(1, 8'hCC, 0, 1, 8'hFF, 16'hAABB, 0, 0);
      add(1, 8'hCC, 1, 0, 8'hFF, 16'hAABB, 0, 0);
      add(1, 8'hDD, 1, 0, 8'hFF, 16'hAABB, 0, 0);
      add(0, 8'h00, 0, 1, 8'h00, 16'hCCDD, 0, 0);
`ifdef UCODE_LOADER_CSUM_EN
      add(1, 8'hFD, 1, 0, 8'h00, 16'hCCDD, 0, 0);
`endif
      add(0, 8'h00, 1, 0, 8'h00, 16'hCCDD, 1, 0);
`ifdef UCODE_LOADER_CSUM_EN
      // frame 3: bad checksum, then SYNC clears the error
      add(1, 8'h55, 1, 0, 8'h00, 16'hCCDD, 1, 0);
      add(1, 8'h10, 1, 0, 8'h00, 16'hCCDD, 0, 0);
      add(1, 8'h01, 1, 0, 8'h00, 16'hCCDD, 0, 0);
      add(1, 8'h00, 1, 0, 8'h00, 16'hCCDD, 0, 0);
      add(1, 8'h01, 1, 0, 8'h00, 16'hCCDD, 0, 0);
      add(0, 8'h00, 0, 1, 8'h10, 16'h0001, 0, 0);
      add(1, 8'h00, 1, 0, 8'h10, 16'h0001, 0, 0);
      add(1, 8'h13, 1, 0, 8'h10, 16'h0001, 0, 1);
      add(1, 8'h55, 1, 0, 8'h10, 16'h0001, 0, 1);
      add(0, 8'h00, 1, 0, 8'h10, 16'h0001, 0, 0);
`endif

      do_reset();
      chk("reset_outputs", {4'h0, outs()}, {4'h0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         @(negedge clk);
         rx_valid = vecs[i].v;
         rx_data  = vecs[i].d;
         chk($sformatf("vec%0d", i), {4'h0, outs()},
             {4'h0, vecs[i].rdy, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].run, vecs[i].err});
      end

      // 256-word frame after junk; every low byte is the SYNC value
      do_reset();
      wr_count = 0;
      send(8'h00);
      send(8'h13);
      send(8'h55);
      send(8'h00);
      send(8'h00);
      for (int k = 0; k < 256; k++) begin
         send(8'(k));
         send(8'h55);
         idle_cycle();
         chk($sformatf("big_wr%0d", k), {8'h0, rx_ready, wr, waddr, wdata},
             {8'h0, 1'b0, 1'b1, 8'(k), 8'(k), 8'h55});
      end
`ifdef UCODE_LOADER_CSUM_EN
      send(8'h00);
`endif
      idle_cycle();
      chk("big_run", {31'h0, run}, 32'd1);
      chk("big_wr_count", wr_count, 32'd256);

      // SYNC in DONE drops run next cycle; reset mid-data suppresses the write
      send(8'h55);
      chk("done_run_before", {31'h0, run}, 32'd1);
      send(8'h20);
      chk("run_dropped", {31'h0, run}, 32'd0);
      send(8'h02);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      chk("mid_wr", {6'h0, wr, waddr, wdata}, {6'h0, 1'b1, 8'h20, 16'h1122});
      send(8'h33);
      send(8'h44);
      rst = 1'b1;
      snap = wr_count;
      @(negedge clk);
      chk("rst_mid_outputs", {4'h0, outs()}, {4'h0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0});
      rst = 1'b0;
      rx_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_no_wr", wr_count, snap);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
